ef_i2c_bus_conditioner: RTL and testbench



---
 rtl/ef_i2c_bus_conditioner.sv | 154 +++++++++++++++
 tb/tb_ef_i2c_bus_conditioner.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ef_i2c_bus_conditioner.sv
// I2C pad-side conditioner: registered open-drain drive enables, synchronised and
// deglitched receive lines, START/STOP detection, bus-busy tracking and SCL-low timeout.

module ef_i2c_glitch_filter #(
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    localparam int unsigned CNT_W = $clog2(FILTER_LEN + 1);

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of the order of always blocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q   <= 1'b1;
            cnt <= '0;
        end else if (d == q) begin
            cnt <= '0;
        end else if (cnt == CNT_W'(FILTER_LEN - 1)) begin
            q   <= d;
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

module ef_i2c_bus_conditioner #(
    parameter int unsigned FILTER_LEN = 4,
    parameter int unsigned TIMEOUT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 m_scl_o,
    input  logic                 m_scl_t,
    input  logic                 m_sda_o,
    input  logic                 m_sda_t,
    input  logic                 scl_pad_i,
    input  logic                 sda_pad_i,
    output logic                 scl_pad_oe,
    output logic                 sda_pad_oe,
    output logic                 scl_f,
    output logic                 sda_f,
    output logic                 start_det,
    output logic                 stop_det,
    output logic                 bus_busy,
    input  logic [TIMEOUT_W-1:0] timeout_limit,
    input  logic                 timeout_clr,
    output logic                 scl_timeout
);
    logic [1:0]           scl_sync;
    logic [1:0]           sda_sync;
    logic                 scl_d;
    logic                 sda_d;
    logic                 start_c;
    logic                 stop_c;
    logic [TIMEOUT_W-1:0] to_cnt;
    logic [TIMEOUT_W-1:0] to_cnt_nxt;

    // Pads are open-drain: only ever pull low, never drive high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_pad_oe <= 1'b0;
            sda_pad_oe <= 1'b0;
        end else begin
            scl_pad_oe <= enable & ~m_scl_t & ~m_scl_o;
            sda_pad_oe <= enable & ~m_sda_t & ~m_sda_o;
        end
    end

    // Synchronisers reset to the idle (released) bus level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], scl_pad_i};
            sda_sync <= {sda_sync[0], sda_pad_i};
        end
    end

    ef_i2c_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
        .clk (clk),
        .rst (rst),
        .d   (scl_sync[1]),
        .q   (scl_f)
    );

    ef_i2c_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
        .clk (clk),
        .rst (rst),
        .d   (sda_sync[1]),
        .q   (sda_f)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_d <= 1'b1;
            sda_d <= 1'b1;
        end else begin
            scl_d <= scl_f;
            sda_d <= sda_f;
        end
    end

    // SCL must be stable high across the SDA transition; a simultaneous SCL edge disqualifies it.
    assign start_c = scl_d & scl_f &  sda_d & ~sda_f;
    assign stop_c  = scl_d & scl_f & ~sda_d &  sda_f;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_det <= 1'b0;
            stop_det  <= 1'b0;
            bus_busy  <= 1'b0;
        end else begin
            start_det <= enable & start_c;
            stop_det  <= enable & stop_c;
            if (!enable)
                bus_busy <= 1'b0;
            else if (start_c)
                bus_busy <= 1'b1;
            else if (stop_c)
                bus_busy <= 1'b0;
        end
    end

    // NOTE: combinational next-state gets a default first so no latch can be inferred.
    always_comb begin
        to_cnt_nxt = '0;
        if (enable && !scl_f)
            to_cnt_nxt = (&to_cnt) ? to_cnt : to_cnt + 1'b1;
    end

    // The flag compares against the next count so it rises on the edge the count reaches the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt      <= '0;
            scl_timeout <= 1'b0;
        end else if (timeout_clr) begin
            to_cnt      <= '0;
            scl_timeout <= 1'b0;
        end else begin
            to_cnt <= to_cnt_nxt;
            if (timeout_limit != '0 && to_cnt_nxt == timeout_limit)
                scl_timeout <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ef_i2c_bus_conditioner.sv
// Directed bench for ef_i2c_bus_conditioner with FILTER_LEN=4, TIMEOUT_W=16.

module tb_ef_i2c_bus_conditioner;
    logic        clk;
    logic        rst;
    logic        enable;
    logic        m_scl_o;
    logic        m_scl_t;
    logic        m_sda_o;
    logic        m_sda_t;
    logic        scl_pad_i;
    logic        sda_pad_i;
    logic        scl_pad_oe;
    logic        sda_pad_oe;
    logic        scl_f;
    logic        sda_f;
    logic        start_det;
    logic        stop_det;
    logic        bus_busy;
    logic [15:0] timeout_limit;
    logic        timeout_clr;
    logic        scl_timeout;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;
    int sda_lows = 0;

    ef_i2c_bus_conditioner #(.FILTER_LEN(4), .TIMEOUT_W(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .m_scl_o       (m_scl_o),
        .m_scl_t       (m_scl_t),
        .m_sda_o       (m_sda_o),
        .m_sda_t       (m_sda_t),
        .scl_pad_i     (scl_pad_i),
        .sda_pad_i     (sda_pad_i),
        .scl_pad_oe    (scl_pad_oe),
        .sda_pad_oe    (sda_pad_oe),
        .scl_f         (scl_f),
        .sda_f         (sda_f),
        .start_det     (start_det),
        .stop_det      (stop_det),
        .bus_busy      (bus_busy),
        .timeout_limit (timeout_limit),
        .timeout_clr   (timeout_clr),
        .scl_timeout   (scl_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Advance while counting any detection pulse and any low sample on sda_f.
    task automatic tick_watch(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (start_det || stop_det) pulses++;
            if (!sda_f) sda_lows++;
        end
    endtask

    task automatic wait_scl_f(input logic val, input int budget, input string tag);
        int n;
        n = 0;
        while (scl_f !== val && n < budget) begin
            tick(1);
            n++;
        end
        check(tag, scl_f, val);
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_scl_pad_oe"}, scl_pad_oe, 0);
        check({pfx, "_sda_pad_oe"}, sda_pad_oe, 0);
        check({pfx, "_scl_f"}, scl_f, 1);
        check({pfx, "_sda_f"}, sda_f, 1);
        check({pfx, "_start_det"}, start_det, 0);
        check({pfx, "_stop_det"}, stop_det, 0);
        check({pfx, "_bus_busy"}, bus_busy, 0);
        check({pfx, "_scl_timeout"}, scl_timeout, 0);
    endtask

    initial begin
        rst           = 1'b1;
        enable        = 1'b0;
        m_scl_o       = 1'b1;
        m_scl_t       = 1'b1;
        m_sda_o       = 1'b1;
        m_sda_t       = 1'b1;
        scl_pad_i     = 1'b1;
        sda_pad_i     = 1'b1;
        timeout_limit = 16'd0;
        timeout_clr   = 1'b0;

        #12;
        check_reset_values("por");
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(2);
        enable = 1'b1;
        tick(1);

        // Drive path: one-cycle latency from master controls to pad enables.
        m_scl_t = 1'b0;
        m_scl_o = 1'b0;
        tick(1);
        check("drv_scl_pull", scl_pad_oe, 1);
        m_sda_t = 1'b0;
        m_sda_o = 1'b1;
        tick(1);
        check("drv_sda_high_no_pull", sda_pad_oe, 0);
        m_sda_o = 1'b0;
        tick(1);
        check("drv_sda_pull", sda_pad_oe, 1);
        m_scl_t = 1'b1;
        m_sda_t = 1'b1;
        tick(1);
        check("drv_scl_release", scl_pad_oe, 0);
        check("drv_sda_release", sda_pad_oe, 0);

        // Three-cycle SDA glitch must never reach sda_f.
        pulses   = 0;
        sda_lows = 0;
        sda_pad_i = 1'b0;
        tick_watch(3);
        sda_pad_i = 1'b1;
        tick_watch(10);
        check("glitch_sda_f_lows", sda_lows, 0);
        check("glitch_pulses", pulses, 0);

        // Clean SDA fall with SCL high: sda_f after 6 edges, START one edge later.
        sda_pad_i = 1'b0;
        tick(5);
        check("filt_not_early", sda_f, 1);
        tick(1);
        check("filt_latency6", sda_f, 0);
        check("start_not_early", start_det, 0);
        tick(1);
        check("start_pulse", start_det, 1);
        check("start_busy", bus_busy, 1);
        tick(1);
        check("start_one_cycle", start_det, 0);
        check("busy_holds", bus_busy, 1);

        // SDA rise with SCL high: STOP.
        sda_pad_i = 1'b1;
        tick(6);
        check("stop_sda_f_up", sda_f, 1);
        check("stop_not_early", stop_det, 0);
        tick(1);
        check("stop_pulse", stop_det, 1);
        check("stop_busy_clear", bus_busy, 0);
        tick(1);
        check("stop_one_cycle", stop_det, 0);

        // SDA toggling while SCL is low is data, not a condition.
        pulses = 0;
        scl_pad_i = 1'b0;
        tick_watch(8);
        sda_pad_i = 1'b0;
        tick_watch(8);
        sda_pad_i = 1'b1;
        tick_watch(8);
        scl_pad_i = 1'b1;
        tick_watch(8);
        check("sclow_pulses", pulses, 0);
        check("sclow_busy", bus_busy, 0);
        check("sclow_scl_f_back", scl_f, 1);

        // SCL and SDA changing together: neither START nor STOP.
        pulses = 0;
        scl_pad_i = 1'b0;
        sda_pad_i = 1'b0;
        tick_watch(10);
        check("simul_fall_scl_f", scl_f, 0);
        check("simul_fall_sda_f", sda_f, 0);
        check("simul_fall_pulses", pulses, 0);
        check("simul_fall_busy", bus_busy, 0);
        scl_pad_i = 1'b1;
        sda_pad_i = 1'b1;
        tick_watch(10);
        check("simul_rise_pulses", pulses, 0);

        // Disabling releases the pads next edge and drops bus_busy.
        sda_pad_i = 1'b0;
        tick(8);
        check("en_busy_set", bus_busy, 1);
        m_scl_t = 1'b0;
        m_scl_o = 1'b0;
        tick(1);
        check("en_scl_pull", scl_pad_oe, 1);
        enable = 1'b0;
        tick(1);
        check("dis_scl_release", scl_pad_oe, 0);
        check("dis_busy_clear", bus_busy, 0);
        enable = 1'b1;
        tick(2);
        check("reen_scl_pull", scl_pad_oe, 1);
        check("reen_busy_stays", bus_busy, 0);

        // Asynchronous reset mid-transfer.
        sda_pad_i = 1'b1;
        tick(8);
        sda_pad_i = 1'b0;
        tick(8);
        check("pre_rst_busy", bus_busy, 1);
        check("pre_rst_pull", scl_pad_oe, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_values("async_rst");
        sda_pad_i = 1'b1;
        m_scl_t   = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(4);

        // SCL-low timeout with limit 100.
        timeout_limit = 16'd100;
        scl_pad_i = 1'b0;
        wait_scl_f(1'b0, 20, "to_scl_fall");
        tick(99);
        check("to_99_no_flag", scl_timeout, 0);
        tick(1);
        check("to_100_flag", scl_timeout, 1);
        timeout_clr = 1'b1;
        tick(1);
        timeout_clr = 1'b0;
        check("to_clr_low", scl_timeout, 0);
        tick(99);
        check("to_reclr_99", scl_timeout, 0);
        tick(1);
        check("to_reclr_100", scl_timeout, 1);
        scl_pad_i = 1'b1;
        wait_scl_f(1'b1, 20, "to_scl_rise");
        tick(5);
        check("to_sticky", scl_timeout, 1);
        timeout_clr = 1'b1;
        tick(1);
        timeout_clr = 1'b0;
        check("to_clr_high", scl_timeout, 0);

        // Limit of zero disables the timeout.
        timeout_limit = 16'd0;
        scl_pad_i = 1'b0;
        tick(300);
        check("to_limit0", scl_timeout, 0);
        scl_pad_i = 1'b1;
        tick(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
